coeff_serializer: RTL and testbench

- Encoder-side counterpart of the decoder's coefficient accumulator.
- Accepts one complete 64-coefficient block as a flat parallel vector and emits it as a serial coefficient stream (value, index, zero-run) toward the entropy encoder.
- Optionally skips zero AC coefficients, reporting the skipped count as a run length.
- Marks the final beat of each block with block_done and an end-of-block indicator.

---
 rtl/jpeg_pkg.sv | 22 ++
 rtl/next_nonzero_finder.sv | 26 ++
 rtl/coeff_serializer.sv | 147 ++++++++++++++
 tb/tb_coeff_serializer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_pkg.sv
// Shared JPEG coefficient-path constants, shared by the accumulator, serializer and entropy encoder.
// Also holds the FSM encoding and small mask helpers.
package jpeg_pkg;

  localparam int unsigned COEFF_WIDTH  = 12;
  localparam int unsigned BLOCK_COEFFS = 64;
  localparam int unsigned IDX_W        = 6;
  localparam int unsigned RUN_W        = 6;

  typedef enum logic [0:0] {
    StIdle,
    StEmit
  } ser_state_e;

  // Positions strictly above idx; the shift wraps to zero at the last slot, giving an empty mask.
  function automatic logic [BLOCK_COEFFS-1:0] above_mask(input logic [IDX_W-1:0] idx);
    logic [BLOCK_COEFFS-1:0] upto;
    upto = (BLOCK_COEFFS'(2) << idx) - BLOCK_COEFFS'(1);
    return ~upto;
  endfunction

endpackage

// File: rtl/next_nonzero_finder.sv
// Masked priority encoder: lowest set mask bit strictly above the current index.
module next_nonzero_finder
  import jpeg_pkg::*;
(
  input  logic [BLOCK_COEFFS-1:0] mask_i,
  input  logic [IDX_W-1:0]        cur_idx_i,
  output logic [IDX_W-1:0]        next_idx_o,
  output logic                    found_o
);

  logic [BLOCK_COEFFS-1:0] cand;

  always_comb begin
    cand       = mask_i & above_mask(cur_idx_i);
    next_idx_o = '0;
    found_o    = 1'b0;
    // Scan downwards so the lowest candidate wins.
    for (int i = BLOCK_COEFFS - 1; i >= 0; i--) begin
      if (cand[i]) begin
        next_idx_o = IDX_W'(i);
        found_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/coeff_serializer.sv
// Serializes one parallel 64-coefficient block into (value, index, run) beats,
// optionally skipping zero AC coefficients and flagging the final beat of each block.
module coeff_serializer
  import jpeg_pkg::*;
#(
  parameter int unsigned WIDTH      = COEFF_WIDTH,
  parameter bit          SKIP_ZEROS = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [WIDTH*BLOCK_COEFFS-1:0] block_in_flat,
  input  logic                          block_in_valid,
  output logic                          block_in_ready,
  output logic [WIDTH-1:0]              coeff_out,
  output logic [IDX_W-1:0]              coeff_index,
  output logic [RUN_W-1:0]              coeff_run,
  output logic                          coeff_valid,
  input  logic                          coeff_ready,
  output logic                          block_done,
  output logic                          coeff_eob
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(BLOCK_COEFFS - 1);

  ser_state_e                    state_q, state_d;
  logic                          ready_q, ready_d;
  logic                          valid_q, valid_d;
  logic [WIDTH*BLOCK_COEFFS-1:0] blk_q, blk_d;
  logic [BLOCK_COEFFS-1:0]       mask_q, mask_d;
  logic [WIDTH-1:0]              out_q, out_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [RUN_W-1:0]              run_q, run_d;
  logic                          done_q, done_d;
  logic                          eob_q, eob_d;

  logic [BLOCK_COEFFS-1:0] in_mask;
  logic [BLOCK_COEFFS-1:0] look_mask;
  logic [IDX_W-1:0]        look_idx;
  logic                    look_found;
  logic [IDX_W-1:0]        nxt_idx;
  logic                    nxt_found;

  // Without zero skipping every slot counts as occupied, so the same stepping logic walks 0..63.
  always_comb begin
    in_mask = '1;
    if (SKIP_ZEROS) begin
      for (int i = 0; i < BLOCK_COEFFS; i++) begin
        in_mask[i] = |block_in_flat[i*WIDTH +: WIDTH];
      end
      in_mask[0] = 1'b1;
    end
  end

  next_nonzero_finder u_finder (
    .mask_i     (mask_q),
    .cur_idx_i  (idx_q),
    .next_idx_o (nxt_idx),
    .found_o    (nxt_found)
  );

  // Lookahead one beat further so block_done is registered alongside the beat it marks.
  assign look_mask  = (state_q == StIdle) ? in_mask : mask_q;
  assign look_idx   = (state_q == StIdle) ? '0 : nxt_idx;
  assign look_found = |(look_mask & above_mask(look_idx));

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    blk_d   = blk_q;
    mask_d  = mask_q;
    out_d   = out_q;
    idx_d   = idx_q;
    run_d   = run_q;
    done_d  = done_q;
    eob_d   = eob_q;

    unique case (state_q)
      StIdle: begin
        if (ready_q && block_in_valid) begin
          blk_d   = block_in_flat;
          mask_d  = in_mask;
          out_d   = block_in_flat[WIDTH-1:0];
          idx_d   = '0;
          run_d   = '0;
          done_d  = ~look_found;
          eob_d   = ~look_found;
          valid_d = 1'b1;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (valid_q && coeff_ready) begin
          if (done_q || !nxt_found) begin
            valid_d = 1'b0;
            done_d  = 1'b0;
            eob_d   = 1'b0;
            state_d = StIdle;
          end else begin
            idx_d  = nxt_idx;
            out_d  = blk_q[int'(nxt_idx)*WIDTH +: WIDTH];
            run_d  = RUN_W'(nxt_idx - idx_q - IDX_W'(1));
            done_d = ~look_found;
            eob_d  = ~look_found && (nxt_idx != LastIdx);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      blk_q   <= '0;
      mask_q  <= '0;
      out_q   <= '0;
      idx_q   <= '0;
      run_q   <= '0;
      done_q  <= 1'b0;
      eob_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      blk_q   <= blk_d;
      mask_q  <= mask_d;
      out_q   <= out_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      done_q  <= done_d;
      eob_q   <= eob_d;
    end
  end

  assign block_in_ready = ready_q;
  assign coeff_valid    = valid_q;
  assign coeff_out      = out_q;
  assign coeff_index    = idx_q;
  assign coeff_run      = run_q;
  assign block_done     = done_q;
  assign coeff_eob      = eob_q;

endmodule

// File: tb/tb_coeff_serializer.sv
// Randomized bench for coeff_serializer: a zero-skipping and a full-stream instance
// are checked beat by beat against an expected-beat list derived from the block contents.
module tb_coeff_serializer;

  localparam int W  = 12;
  localparam int N  = 64;
  localparam int BW = W * N;

  typedef logic [W+13:0] beat_t;  // {coeff, index, run, done, eob}

  logic          clk;
  logic          rst_n;
  logic [BW-1:0] blk_flat;
  logic          in_valid;
  logic          coeff_ready;
  logic          sel_full;

  logic          s_ready, s_valid, s_done, s_eob;
  logic [W-1:0]  s_out;
  logic [5:0]    s_idx, s_run;
  logic          f_ready, f_valid, f_done, f_eob;
  logic [W-1:0]  f_out;
  logic [5:0]    f_idx, f_run;

  beat_t s_beat, f_beat, obs_beat;
  logic  obs_valid, obs_ready;

  int n_checks;
  int n_errors;
  beat_t exp_q[$];

  coeff_serializer #(.WIDTH(W), .SKIP_ZEROS(1'b1)) u_dut_skip (
    .clk            (clk),
    .rst_n          (rst_n),
    .block_in_flat  (blk_flat),
    .block_in_valid (in_valid & ~sel_full),
    .block_in_ready (s_ready),
    .coeff_out      (s_out),
    .coeff_index    (s_idx),
    .coeff_run      (s_run),
    .coeff_valid    (s_valid),
    .coeff_ready    (coeff_ready),
    .block_done     (s_done),
    .coeff_eob      (s_eob)
  );

  coeff_serializer #(.WIDTH(W), .SKIP_ZEROS(1'b0)) u_dut_full (
    .clk            (clk),
    .rst_n          (rst_n),
    .block_in_flat  (blk_flat),
    .block_in_valid (in_valid & sel_full),
    .block_in_ready (f_ready),
    .coeff_out      (f_out),
    .coeff_index    (f_idx),
    .coeff_run      (f_run),
    .coeff_valid    (f_valid),
    .coeff_ready    (coeff_ready),
    .block_done     (f_done),
    .coeff_eob      (f_eob)
  );

  assign s_beat    = {s_out, s_idx, s_run, s_done, s_eob};
  assign f_beat    = {f_out, f_idx, f_run, f_done, f_eob};
  assign obs_beat  = sel_full ? f_beat : s_beat;
  assign obs_valid = sel_full ? f_valid : s_valid;
  assign obs_ready = sel_full ? f_ready : s_ready;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected beats straight from the block contents: DC always, AC when nonzero (or all if full).
  function automatic void build_model(input logic [BW-1:0] blk, input bit full);
    int          prev;
    int          last;
    logic [W-1:0] v;
    beat_t       b;
    exp_q.delete();
    prev = -1;
    for (int i = 0; i < N; i++) begin
      v = blk[i*W +: W];
      if (full || i == 0 || v != '0) begin
        b = {v, 6'(i), (full ? 6'd0 : 6'(i - prev - 1)), 1'b0, 1'b0};
        exp_q.push_back(b);
        prev = i;
      end
    end
    last = exp_q.size() - 1;
    b = exp_q[last];
    b[1] = 1'b1;
    b[0] = !full && (prev < 63);
    exp_q[last] = b;
  endfunction

  function automatic logic [BW-1:0] with_slot(input logic [BW-1:0] b, input int i, input int v);
    b[i*W +: W] = W'(v);
    return b;
  endfunction

  // mode 0: always ready; 1: random ready; 2: stall 3 cycles on index 5.
  task automatic run_block(input logic [BW-1:0] blk, input int mode, input int abort_after);
    beat_t exp_b;
    beat_t held;
    bit    holding, fin, aborted;
    int    hs, stall, cyc;
    build_model(blk, sel_full);
    check_eq("in_ready_idle", 64'(obs_ready), 64'd1);
    blk_flat = blk;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) blk_flat[i*W +: W] = W'($urandom);
    holding = 1'b0; fin = 1'b0; aborted = 1'b0;
    hs = 0; stall = 0; cyc = 0;
    held = '0;
    while (!fin && cyc < 400) begin
      cyc++;
      check_eq("valid_up", 64'(obs_valid), 64'd1);
      if (holding) check_eq("hold_beat", 64'(obs_beat), 64'(held));
      case (mode)
        1:       coeff_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (obs_beat[13:8] == 6'd5 && stall < 3) begin
            coeff_ready = 1'b0;
            stall++;
          end else begin
            coeff_ready = 1'b1;
          end
        end
        default: coeff_ready = 1'b1;
      endcase
      if (obs_valid && coeff_ready) begin
        holding = 1'b0;
        exp_b = exp_q.pop_front();
        check_eq("beat", 64'(obs_beat), 64'(exp_b));
        hs++;
        if (exp_b[1]) fin = 1'b1;
        if (hs == abort_after) begin
          @(negedge clk);
          rst_n = 1'b0;
          @(negedge clk);
          check_eq("abort_reset", 64'({obs_valid, obs_ready, obs_beat}), 64'd0);
          rst_n = 1'b1;
          @(negedge clk);
          check_eq("abort_ready", 64'(obs_ready), 64'd1);
          fin = 1'b1;
          aborted = 1'b1;
        end
      end else begin
        holding = obs_valid;
        held    = obs_beat;
      end
      if (!aborted) @(negedge clk);
    end
    if (!fin) begin
      check_eq("block_timeout", 64'(fin), 64'd1);
    end else if (!aborted) begin
      check_eq("bubble_idle", 64'({obs_valid, obs_ready}), 64'b01);
    end
    coeff_ready = 1'b1;
  endtask

  initial begin
    logic [BW-1:0] blk;
    int            dens;
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    coeff_ready = 1'b1;
    sel_full    = 1'b0;
    blk_flat    = '0;
    repeat (3) @(negedge clk);
    check_eq("reset_skip", 64'({s_valid, s_ready, s_beat}), 64'd0);
    check_eq("reset_full", 64'({f_valid, f_ready, f_beat}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_reset", 64'({s_ready, f_ready}), 64'b11);

    // Zero-skipping instance: directed cases, then random sparse blocks.
    run_block('0, 0, -1);
    blk = '0;
    blk = with_slot(blk, 0, 100);
    blk = with_slot(blk, 5, -3);
    blk = with_slot(blk, 63, 7);
    run_block(blk, 0, -1);
    run_block(blk, 2, -1);
    blk = with_slot('0, 0, 5);
    blk = with_slot(blk, 2, 1);
    run_block(blk, 0, -1);
    run_block(with_slot('0, 0, -8), 0, -1);
    run_block(with_slot('0, 63, 1), 0, -1);
    blk = with_slot('0, 0, 1);
    blk = with_slot(blk, 10, 2);
    blk = with_slot(blk, 20, 3);
    run_block(blk, 0, 2);
    run_block(blk, 1, -1);
    for (int b = 0; b < 40; b++) begin
      dens = (b % 7 == 0) ? 100 : $urandom_range(0, 40);
      blk = '0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 99) < dens) blk[i*W +: W] = W'($urandom);
      end
      run_block(blk, 1, -1);
    end

    // Full-stream instance: ramp, zeros, random.
    sel_full = 1'b1;
    @(negedge clk);
    blk = '0;
    for (int i = 0; i < N; i++) blk[i*W +: W] = W'(i - 32);
    run_block(blk, 0, -1);
    run_block(blk, 1, -1);
    run_block('0, 0, -1);
    for (int b = 0; b < 4; b++) begin
      blk = '0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 1) != 0) blk[i*W +: W] = W'($urandom);
      end
      run_block(blk, 1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
